// File: rtl/sqrt_stage3.sv
// rtl/sqrt_stage3.sv - square-root stage 3: two restoring trial-subtract root bits, one per clock
// Optional macro SQRT_S3_OVERLAP_EN: DONE may retire a result and capture new input on one edge.
module sqrt_stage3 #(
  parameter int ROOT_IN_W = 4,
  parameter int STEPS     = 2,
  parameter int REM_W     = 10,
  parameter int RADL_W    = 8,
  localparam int ROOT_OUT_W = ROOT_IN_W + STEPS,
  localparam int RADL_OUT_W = RADL_W - 2 * STEPS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROOT_IN_W-1:0]  in_root,
  input  logic [REM_W-1:0]      in_rem,
  input  logic [RADL_W-1:0]     in_rad_low,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ROOT_OUT_W-1:0] out_root,
  output logic [REM_W-1:0]      out_rem,
  output logic [RADL_OUT_W-1:0] out_rad_low
);

  localparam int CMP_W = REM_W + 2;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  state_t                state_q;
  logic [ROOT_OUT_W-1:0] root_q, root_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [RADL_W-1:0]     rad_q, rad_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  out_valid_q;
  logic [ROOT_OUT_W-1:0] out_root_q;
  logic [REM_W-1:0]      out_rem_q;
  logic [RADL_OUT_W-1:0] out_rad_q;

  logic [CMP_W-1:0]      rem_ext, trial, diff, rem_sel;
  logic                  fits;
  logic                  unused_rem_hi;

  // One restoring iteration; the remainder never exceeds 2*root, so it fits back into REM_W.
  always_comb begin
    rem_ext = {rem_q, rad_q[RADL_W-1 -: 2]};
    trial   = CMP_W'({root_q, 2'b01});
    diff    = rem_ext - trial;
    fits    = (rem_ext >= trial);
    rem_sel = fits ? diff : rem_ext;
    rem_d   = rem_sel[REM_W-1:0];
    root_d  = {root_q[ROOT_OUT_W-2:0], fits};
    rad_d   = rad_q << 2;
  end

  assign unused_rem_hi = |rem_sel[CMP_W-1:REM_W];

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
`ifdef SQRT_S3_OVERLAP_EN
      DONE:    in_ready = out_ready;
`endif
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      root_q      <= '0;
      rem_q       <= '0;
      rad_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_root_q  <= '0;
      out_rem_q   <= '0;
      out_rad_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            root_q  <= ROOT_OUT_W'(in_root);
            rem_q   <= in_rem;
            rad_q   <= in_rad_low;
            cnt_q   <= '0;
            state_q <= STEP;
          end
        end
        STEP: begin
          root_q <= root_d;
          rem_q  <= rem_d;
          rad_q  <= rad_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            out_root_q  <= root_d;
            out_rem_q   <= rem_d;
            out_rad_q   <= rad_d[RADL_W-1 -: RADL_OUT_W];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
`ifdef SQRT_S3_OVERLAP_EN
            if (in_valid) begin
              root_q  <= ROOT_OUT_W'(in_root);
              rem_q   <= in_rem;
              rad_q   <= in_rad_low;
              cnt_q   <= '0;
              state_q <= STEP;
            end
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_root    = out_root_q;
  assign out_rem     = out_rem_q;
  assign out_rad_low = out_rad_q;

endmodule

// File: tb/tb_sqrt_stage3.sv
// tb/tb_sqrt_stage3.sv - directed-vector self-checking bench for sqrt_stage3
// Expected result spacing follows SQRT_S3_OVERLAP_EN when it is defined.
module tb_sqrt_stage3;

`ifdef SQRT_S3_OVERLAP_EN
  localparam int EXP_GAP = 3;
`else
  localparam int EXP_GAP = 4;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_root;
  logic [9:0] in_rem;
  logic [7:0] in_rad_low;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_root;
  logic [9:0] out_rem;
  logic [3:0] out_rad_low;

  int n_tests = 0;
  int n_fail  = 0;

  sqrt_stage3 dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_root     (in_root),
    .in_rem      (in_rem),
    .in_rad_low  (in_rad_low),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_root    (out_root),
    .out_rem     (out_rem),
    .out_rad_low (out_rad_low)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one input at a negedge and returns how many negedges later out_valid shows (-1 if never).
  task automatic do_vec(input logic [3:0] r, input logic [9:0] m, input logic [7:0] d,
                        output int lat, output logic rdy);
    @(negedge clock);
    in_root = r; in_rem = m; in_rad_low = d; in_valid = 1'b1; out_ready = 1'b1;
    rdy = in_ready;
    @(negedge clock);
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_root = '0; in_rem = '0; in_rad_low = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_root !== 6'd0) begin n_fail++; $display("FAIL reset_out_root got=%0d exp=0", out_root); end
    n_tests++; if (out_rem !== 10'd0) begin n_fail++; $display("FAIL reset_out_rem got=%0d exp=0", out_rem); end
    n_tests++; if (out_rad_low !== 4'd0) begin n_fail++; $display("FAIL reset_out_rad_low got=%0h exp=0", out_rad_low); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_vector(input string name, input logic [3:0] r, input logic [9:0] m,
                             input logic [7:0] d, input logic [5:0] er, input logic [9:0] em,
                             input logic [3:0] ed);
    int   lat;
    logic rdy;
    do_vec(r, m, d, lat, rdy);
    n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL %s in_ready got=%b exp=1", name, rdy); end
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL %s latency got=%0d exp=3", name, lat); end
    n_tests++; if (out_root !== er) begin n_fail++; $display("FAIL %s out_root got=%0d exp=%0d", name, out_root, er); end
    n_tests++; if (out_rem !== em) begin n_fail++; $display("FAIL %s out_rem got=%0d exp=%0d", name, out_rem, em); end
    n_tests++; if (out_rad_low !== ed) begin n_fail++; $display("FAIL %s out_rad_low got=%0h exp=%0h", name, out_rad_low, ed); end
    @(negedge clock);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s valid_one_cycle got=%b exp=0", name, out_valid); end
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    @(negedge clock);
    in_root = 4'd15; in_rem = 10'd30; in_rad_low = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clock);
    // Junk held valid through STEP and DONE must never be captured.
    in_root = 4'd1; in_rem = 10'd0; in_rad_low = 8'h00;
    for (int k = 0; k < 10; k++) begin
      if (out_valid === 1'b1) begin seen = 1; break; end
      @(negedge clock);
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL bp_timeout out_valid never rose"); end
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
      n_tests++; if (out_root !== 6'd63) begin n_fail++; $display("FAIL bp_root[%0d] got=%0d exp=63", i, out_root); end
      n_tests++; if (out_rem !== 10'd126) begin n_fail++; $display("FAIL bp_rem[%0d] got=%0d exp=126", i, out_rem); end
      n_tests++; if (out_rad_low !== 4'hF) begin n_fail++; $display("FAIL bp_rad[%0d] got=%0h exp=f", i, out_rad_low); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      @(negedge clock);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_midop();
    @(negedge clock);
    in_root = 4'd15; in_rem = 10'd30; in_rad_low = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1; in_root = 4'd5;
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_root !== 6'd0) begin n_fail++; $display("FAIL midrst_root got=%0d exp=0", out_root); end
    n_tests++; if (out_rem !== 10'd0) begin n_fail++; $display("FAIL midrst_rem got=%0d exp=0", out_rem); end
    n_tests++; if (out_rad_low !== 4'd0) begin n_fail++; $display("FAIL midrst_rad got=%0h exp=0", out_rad_low); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    test_vector("after_reset", 4'd0, 10'd0, 8'h90, 6'd3, 10'd0, 4'h0);
  endtask

  task automatic test_back_to_back();
    int t[2] = '{-100, -100};
    int nres = 0;
    int nacc = 0;
    bit pend;
    @(negedge clock);
    in_root = 4'd15; in_rem = 10'd30; in_rad_low = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    pend = in_ready;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (out_valid === 1'b1 && nres < 2) begin
        t[nres] = c;
        if (nres == 0) begin
          n_tests++; if (out_root !== 6'd63 || out_rem !== 10'd126 || out_rad_low !== 4'hF) begin
            n_fail++; $display("FAIL b2b_first got=%0d/%0d/%0h exp=63/126/f", out_root, out_rem, out_rad_low);
          end
        end else begin
          n_tests++; if (out_root !== 6'd3 || out_rem !== 10'd0 || out_rad_low !== 4'h0) begin
            n_fail++; $display("FAIL b2b_second got=%0d/%0d/%0h exp=3/0/0", out_root, out_rem, out_rad_low);
          end
        end
        nres++;
      end
      if (pend) begin
        nacc++;
        if (nacc == 1) begin
          in_root = 4'd0; in_rem = 10'd0; in_rad_low = 8'h90;
        end else begin
          in_valid = 1'b0;
        end
      end
      pend = in_valid && in_ready;
    end
    n_tests++; if (nres != 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", nres); end
    n_tests++; if (t[1] - t[0] != EXP_GAP) begin n_fail++; $display("FAIL b2b_gap got=%0d exp=%0d", t[1] - t[0], EXP_GAP); end
  endtask

  initial begin
    test_reset();
    test_vector("full_scale", 4'd15, 10'd30, 8'hFF, 6'd63, 10'd126, 4'hF);
    test_vector("exact_square", 4'd2, 10'd0, 8'h00, 6'd8, 10'd0, 4'h0);
    test_vector("small_radicand", 4'd0, 10'd0, 8'h90, 6'd3, 10'd0, 4'h0);
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
